// File: rtl/bsg_mem_wr_sched_pkg.sv
// Shared types and sizing helpers for the multiport write scheduler.
// The request struct is sized for the widest memory; users slice the low bits.
package bsg_mem_wr_sched_pkg;

    localparam int WR_SCHED_ADDR_W_MAX = 32;
    localparam int WR_SCHED_DATA_W_MAX = 64;

    function automatic int wait_cnt_width(input int starve_limit);
        return $clog2(starve_limit + 1);
    endfunction

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [WR_SCHED_ADDR_W_MAX-1:0] addr;
        logic [WR_SCHED_DATA_W_MAX-1:0] data;
    } wr_req_s;

endpackage

// File: rtl/bsg_mem_wr_sched_starve_ctr.sv
// Per-requester wait counter: clears on clear_i, otherwise counts up and
// saturates at limit_p; starved_o flags the saturated state.
module bsg_mem_wr_sched_starve_ctr
    import bsg_mem_wr_sched_pkg::*;
#(
    parameter int limit_p = 15
)(
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    output logic starved_o
);

    localparam int cnt_w_lp = wait_cnt_width(limit_p);
    localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(limit_p);

    logic [cnt_w_lp-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_cnt <= '0;
        else if (clear_i)
            r_cnt <= '0;
        else if (r_cnt != limit_lp)
            r_cnt <= r_cnt + cnt_w_lp'(1);
    end

    assign starved_o = (r_cnt == limit_lp);

endmodule

// File: rtl/bsg_mem_multiport_wr_sched.sv
// Rotating-priority scheduler sharing W memory write ports among R requesters,
// holding back grants that would collide with reads or with other writes.
module bsg_mem_multiport_wr_sched
    import bsg_mem_wr_sched_pkg::*;
#(
    parameter int width_p                 = 8,
    parameter int els_p                   = 16,
    parameter int reqs_p                  = 4,
    parameter int write_ports_p           = 2,
    parameter int read_ports_p            = 1,
    parameter int read_write_same_addr_p  = 0,
    parameter int write_write_same_addr_p = 0,
    parameter int starve_limit_p          = 15,
    localparam int addr_width_lp          = safe_clog2(els_p)
)(
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [reqs_p-1:0]                      req_v_i,
    input  logic [reqs_p*addr_width_lp-1:0]        req_addr_i,
    input  logic [reqs_p*width_p-1:0]              req_data_i,
    output logic [reqs_p-1:0]                      req_yumi_o,
    input  logic [read_ports_p-1:0]                r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0]  r_addr_i,
    output logic [write_ports_p-1:0]               w_v_o,
    output logic [write_ports_p*addr_width_lp-1:0] w_addr_o,
    output logic [write_ports_p*width_p-1:0]       w_data_o,
    output logic [reqs_p-1:0]                      starved_o
);

    localparam int aw_lp    = addr_width_lp;
    localparam int ptr_w_lp = safe_clog2(reqs_p);

    logic [ptr_w_lp-1:0]      r_ptr;
    logic [ptr_w_lp-1:0]      w_ptr_nxt;
    logic                     w_any_grant;
    logic [reqs_p-1:0]        w_starved;
    logic [reqs_p-1:0]        w_clear;
    logic [reqs_p-1:0]        w_yumi;
    logic [write_ports_p-1:0] w_port_v;
    wr_req_s                  w_req  [reqs_p];
    wr_req_s                  w_port [write_ports_p];

    always_comb begin
        for (int i = 0; i < reqs_p; i++) begin
            w_req[i] = '0;
            w_req[i].addr[aw_lp-1:0]   = req_addr_i[i*aw_lp +: aw_lp];
            w_req[i].data[width_p-1:0] = req_data_i[i*width_p +: width_p];
        end
    end

    // Single unrolled walk: start at the lowest starved requester if any,
    // otherwise at r_ptr; k-th grant lands on write port k.
    always_comb begin
        int   start_idx;
        int   idx;
        int   n_grant;
        int   last_idx;
        logic blocked;

        start_idx = int'(r_ptr);
        for (int i = reqs_p - 1; i >= 0; i--)
            if (w_starved[i]) start_idx = i;

        n_grant  = 0;
        last_idx = int'(r_ptr);
        idx      = 0;
        blocked  = 1'b0;
        w_yumi   = '0;
        w_port_v = '0;
        for (int k = 0; k < write_ports_p; k++) w_port[k] = '0;

        for (int s = 0; s < reqs_p; s++) begin
            idx     = (start_idx + s) % reqs_p;
            blocked = !reset_n_i || !req_v_i[idx] || (n_grant >= write_ports_p);
            if (read_write_same_addr_p == 0)
                for (int j = 0; j < read_ports_p; j++)
                    if (r_v_i[j] && (r_addr_i[j*aw_lp +: aw_lp] == req_addr_i[idx*aw_lp +: aw_lp]))
                        blocked = 1'b1;
            if (write_write_same_addr_p == 0)
                for (int k = 0; k < write_ports_p; k++)
                    if (w_port_v[k] && (w_port[k].addr == w_req[idx].addr))
                        blocked = 1'b1;
            if (!blocked) begin
                w_port_v[n_grant] = 1'b1;
                w_port[n_grant]   = w_req[idx];
                w_yumi[idx]       = 1'b1;
                n_grant           = n_grant + 1;
                last_idx          = idx;
            end
        end

        w_any_grant = (n_grant != 0);
        w_ptr_nxt   = ptr_w_lp'((last_idx + 1) % reqs_p);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_ptr <= '0;
        else if (w_any_grant)
            r_ptr <= w_ptr_nxt;
    end

    assign w_clear = ~req_v_i | w_yumi;

    bsg_mem_wr_sched_starve_ctr #(
        .limit_p (starve_limit_p)
    ) u_ctr [reqs_p-1:0] (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_clear),
        .starved_o (w_starved)
    );

    assign req_yumi_o = w_yumi;
    assign w_v_o      = w_port_v;
    assign starved_o  = w_starved & {reqs_p{reset_n_i}};

    for (genvar k = 0; k < write_ports_p; k++) begin : g_port
        assign w_addr_o[k*aw_lp +: aw_lp]     = w_port[k].addr[aw_lp-1:0];
        assign w_data_o[k*width_p +: width_p] = w_port[k].data[width_p-1:0];
    end

    for (genvar i = 0; i < reqs_p; i++) begin : g_hold_chk
        a_req_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
            (req_v_i[i] && !req_yumi_o[i]) |=> req_v_i[i]);
    end

    if (write_write_same_addr_p == 0) begin : g_ww_chk
        for (genvar k = 0; k < write_ports_p; k++) begin : g_k
            for (genvar l = k + 1; l < write_ports_p; l++) begin : g_l
                a_ww_addr: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                    !(w_v_o[k] && w_v_o[l] &&
                      (w_addr_o[k*aw_lp +: aw_lp] == w_addr_o[l*aw_lp +: aw_lp])));
            end
        end
    end

endmodule

// File: tb/tb_bsg_mem_multiport_wr_sched.sv
// Directed bench: dut_a enforces both address rules, dut_b waives both.
module tb_bsg_mem_multiport_wr_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]      a_v, b_v, a_yumi, b_yumi, a_starved, b_starved;
    logic [3:0][3:0] a_addr, b_addr;
    logic [3:0][7:0] a_data, b_data;
    logic [1:0]      a_rv, b_rv, a_wv, b_wv;
    logic [1:0][3:0] a_raddr, b_raddr, a_waddr, b_waddr;
    logic [1:0][7:0] a_wdata, b_wdata;

    int checks = 0;
    int errors = 0;

    bsg_mem_multiport_wr_sched #(
        .width_p(8), .els_p(16), .reqs_p(4), .write_ports_p(2), .read_ports_p(2),
        .read_write_same_addr_p(0), .write_write_same_addr_p(0), .starve_limit_p(3)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(a_v), .req_addr_i(a_addr), .req_data_i(a_data), .req_yumi_o(a_yumi),
        .r_v_i(a_rv), .r_addr_i(a_raddr),
        .w_v_o(a_wv), .w_addr_o(a_waddr), .w_data_o(a_wdata), .starved_o(a_starved)
    );

    bsg_mem_multiport_wr_sched #(
        .width_p(8), .els_p(16), .reqs_p(4), .write_ports_p(2), .read_ports_p(2),
        .read_write_same_addr_p(1), .write_write_same_addr_p(1), .starve_limit_p(3)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(b_v), .req_addr_i(b_addr), .req_data_i(b_data), .req_yumi_o(b_yumi),
        .r_v_i(b_rv), .r_addr_i(b_raddr),
        .w_v_o(b_wv), .w_addr_o(b_waddr), .w_data_o(b_wdata), .starved_o(b_starved)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_v     = '0; b_v = '0;
        a_addr  = '0; b_addr = '0;
        a_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        a_rv    = '0; b_rv = '0;
        a_raddr = '0; b_raddr = '0;
        #1;
        chk("rst_yumi", a_yumi, 4'b0000);
        chk("rst_wv", a_wv, 2'b00);
        chk("rst_starved", a_starved, 4'b0000);
        chk("rst_waddr", a_waddr, 8'h00);
        chk("rst_wdata", a_wdata, 16'h0000);
        chk("rst_ptr", dut_a.r_ptr, 2'd0);

        // Requests present while in reset must still see no grant.
        a_v    = 4'b1111;
        a_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        chk("rst_force_yumi", a_yumi, 4'b0000);
        chk("rst_force_wv", a_wv, 2'b00);
        rst_n = 1'b1;
        #1;

        // Test 1: rotating priority.
        chk("t1_c1_yumi", a_yumi, 4'b0011);
        chk("t1_c1_wv", a_wv, 2'b11);
        chk("t1_c1_p0addr", a_waddr[0], 4'd1);
        chk("t1_c1_p1addr", a_waddr[1], 4'd2);
        chk("t1_c1_p1data", a_wdata[1], 8'hA1);
        tick();
        chk("t1_ptr2", dut_a.r_ptr, 2'd2);
        chk("t1_c2_yumi", a_yumi, 4'b1100);
        chk("t1_c2_p0addr", a_waddr[0], 4'd3);
        chk("t1_c2_p1addr", a_waddr[1], 4'd4);
        tick();
        chk("t1_ptr_wrap", dut_a.r_ptr, 2'd0);
        a_v = 4'b0011;
        #1;
        chk("t1_c3_yumi", a_yumi, 4'b0011);
        tick();
        a_v = 4'b1100;
        #1;
        chk("t1_c4_yumi", a_yumi, 4'b1100);
        tick();

        // Test 2: write/write collision, ptr back at 0.
        chk("t2_ptr0", dut_a.r_ptr, 2'd0);
        a_v    = 4'b0111;
        a_addr = {4'd0, 4'd6, 4'd5, 4'd5};
        #1;
        chk("t2_yumi", a_yumi, 4'b0101);
        chk("t2_p0addr", a_waddr[0], 4'd5);
        chk("t2_p1addr", a_waddr[1], 4'd6);
        chk("t2_p1data", a_wdata[1], 8'hA2);
        tick();
        a_v = 4'b0010;
        #1;
        chk("t2_next_yumi", a_yumi, 4'b0010);
        chk("t2_next_wv", a_wv, 2'b01);
        chk("t2_next_p0data", a_wdata[0], 8'hA1);
        chk("t2_next_p1addr", a_waddr[1], 4'd0);
        tick();

        // Test 3: write vs. read on port 0.
        a_v        = 4'b0001;
        a_addr[0]  = 4'd7;
        a_rv       = 2'b01;
        a_raddr[0] = 4'd7;
        #1;
        chk("t3_blk_yumi", a_yumi, 4'b0000);
        chk("t3_blk_wv", a_wv, 2'b00);
        tick();
        chk("t3_ptr_hold", dut_a.r_ptr, 2'd2);
        chk("t3_blk2_yumi", a_yumi, 4'b0000);
        chk("t3_not_starved", a_starved, 4'b0000);
        a_rv = 2'b00;
        #1;
        chk("t3_rel_yumi", a_yumi, 4'b0001);
        chk("t3_rel_p0addr", a_waddr[0], 4'd7);
        tick();

        // Test 4: starvation, read collision on read port 1.
        chk("t4_ptr1", dut_a.r_ptr, 2'd1);
        a_v        = 4'b1000;
        a_addr     = {4'd9, 4'd3, 4'd2, 4'd1};
        a_rv       = 2'b10;
        a_raddr[1] = 4'd9;
        #1;
        chk("t4_blk_yumi", a_yumi, 4'b0000);
        tick();
        tick();
        chk("t4_cnt2_starved", a_starved, 4'b0000);
        tick();
        chk("t4_starved", a_starved, 4'b1000);
        chk("t4_starved_blk", a_yumi, 4'b0000);
        tick();
        chk("t4_sat_starved", a_starved, 4'b1000);
        a_v  = 4'b1111;
        a_rv = 2'b00;
        #1;
        chk("t4_grant_yumi", a_yumi, 4'b1001);
        chk("t4_grant_p0addr", a_waddr[0], 4'd9);
        chk("t4_grant_p1data", a_wdata[1], 8'hA0);
        tick();
        chk("t4_cleared", a_starved, 4'b0000);
        a_v = 4'b0110;
        #1;
        chk("t4_after_yumi", a_yumi, 4'b0110);
        tick();

        // Test 5: asynchronous reset mid-burst.
        a_v    = 4'b1111;
        a_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        chk("t5_burst_yumi", a_yumi, 4'b1001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_yumi", a_yumi, 4'b0000);
        chk("t5_rst_wv", a_wv, 2'b00);
        chk("t5_rst_starved", a_starved, 4'b0000);
        chk("t5_rst_waddr", a_waddr, 8'h00);
        chk("t5_rst_ptr", dut_a.r_ptr, 2'd0);
        a_v = 4'b0000;
        tick();
        rst_n = 1'b1;
        a_v   = 4'b1111;
        #1;
        chk("t5_post_ptr", dut_a.r_ptr, 2'd0);
        chk("t5_post_yumi", a_yumi, 4'b0011);
        tick();
        a_v = 4'b1100;
        #1;
        chk("t5_post2_yumi", a_yumi, 4'b1100);
        tick();
        a_v = 4'b0000;

        // Test 6: same-address rules waived on dut_b.
        b_v    = 4'b0111;
        b_addr = {4'd0, 4'd6, 4'd5, 4'd5};
        #1;
        chk("t6_ww_yumi", b_yumi, 4'b0011);
        chk("t6_ww_wv", b_wv, 2'b11);
        chk("t6_ww_p0addr", b_waddr[0], 4'd5);
        chk("t6_ww_p1addr", b_waddr[1], 4'd5);
        chk("t6_ww_p1data", b_wdata[1], 8'hB1);
        tick();
        b_v = 4'b0100;
        #1;
        chk("t6_ww_next_yumi", b_yumi, 4'b0100);
        chk("t6_ww_next_p0addr", b_waddr[0], 4'd6);
        tick();
        b_v        = 4'b0001;
        b_addr[0]  = 4'd7;
        b_rv       = 2'b01;
        b_raddr[0] = 4'd7;
        #1;
        chk("t6_rw_yumi", b_yumi, 4'b0001);
        chk("t6_rw_wv", b_wv, 2'b01);
        chk("t6_rw_p0addr", b_waddr[0], 4'd7);
        tick();
        b_v  = 4'b0000;
        b_rv = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
